// File: rtl/cga_alu_mdseq.sv
// Shift-and-add multiply / non-restoring divide sequencer for the CGA ALU.
// Decodes Q mux select and ALU step command from a five-state controller.
module cga_alu_mdseq (
  input  logic       ALUCLK,
  input  logic       RST_n,
  input  logic       START,
  input  logic       OPDIV,
  input  logic       ABORT,
  input  logic       Q15,
  input  logic       F15,
  output logic [1:0] QSEL_1_0,
  output logic       QLI,
  output logic [2:0] ALUOP_2_0,
  output logic       BUSY,
  output logic       DONE,
  output logic [3:0] STEP_3_0
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_FIX,
    S_FIN
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_step;
  logic       r_neg;
  logic       r_opdiv;

  always_ff @(posedge ALUCLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state <= S_IDLE;
      r_step  <= '0;
      r_neg   <= 1'b0;
      r_opdiv <= 1'b0;
    end else begin
      r_state <= w_next;
      // An aborted cycle leaves all bookkeeping untouched.
      if (!ABORT) begin
        case (r_state)
          S_IDLE: if (START) r_opdiv <= OPDIV;
          S_LOAD: begin
            r_step <= 4'd15;
            r_neg  <= 1'b0;
          end
          S_ITER: begin
            r_step <= r_step - 4'd1;
            if (r_opdiv) r_neg <= F15;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (START && !ABORT) w_next = S_LOAD;
      S_LOAD: w_next = ABORT ? S_IDLE : S_ITER;
      S_ITER: begin
        if (ABORT)              w_next = S_IDLE;
        else if (r_step == '0)  w_next = r_opdiv ? S_FIX : S_FIN;
      end
      S_FIX:  w_next = ABORT ? S_IDLE : S_FIN;
      S_FIN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    QSEL_1_0  = 2'b00;
    ALUOP_2_0 = 3'b000;
    QLI       = 1'b0;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    case (r_state)
      S_LOAD: begin
        QSEL_1_0 = 2'b01;
        BUSY     = 1'b1;
      end
      S_ITER: begin
        QSEL_1_0 = 2'b10;
        BUSY     = 1'b1;
        if (r_opdiv) begin
          ALUOP_2_0 = r_neg ? 3'b010 : 3'b011;
          QLI       = ~F15;
        end else begin
          ALUOP_2_0 = Q15 ? 3'b010 : 3'b001;
        end
      end
      S_FIX: begin
        BUSY      = 1'b1;
        ALUOP_2_0 = r_neg ? 3'b100 : 3'b000;
      end
      S_FIN: DONE = 1'b1;
      default: ;
    endcase
    if (ABORT) begin
      QSEL_1_0  = 2'b00;
      ALUOP_2_0 = 3'b000;
      QLI       = 1'b0;
    end
  end

  assign STEP_3_0 = r_step;

endmodule

// File: doc/cga_alu_mdseq.md
CGA_ALU_MDSEQ -- requirements
Module: cga_alu_mdseq

Interface
REQ-001 The block SHALL have the port ALUCLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port RST_n, input, 1 bit: asynchronous active-low reset.
REQ-003 The block SHALL have the port START, input, 1 bit: request to begin an operation; sampled only in IDLE.
REQ-004 The block SHALL have the port OPDIV, input, 1 bit: operation select, 0 = multiply, 1 = divide; captured with START.
REQ-005 The block SHALL have the port ABORT, input, 1 bit: synchronous cancel of a running operation.
REQ-006 The block SHALL have the port Q15, input, 1 bit: current Q register bit 15.
REQ-007 The block SHALL have the port F15, input, 1 bit: sign of the current ALU result F.
REQ-008 The block SHALL have the port QSEL_1_0, output, 2 bits: Q register mux select, with 00 = hold, 01 = load F, 10 = shift up with QLI into bit 0, 11 = shift down.
REQ-009 The block SHALL have the port QLI, output, 1 bit: serial bit shifted into Q bit 0.
REQ-010 The block SHALL have the port ALUOP_2_0, output, 3 bits: ALU step command, with 000 = hold A, 001 = A<=2A, 010 = A<=2A+M, 011 = A<=2A-M, 100 = A<=A+M (restore).
REQ-011 The block SHALL have the port BUSY, output, 1 bit: high from the LOAD state through FIX, inclusive.
REQ-012 The block SHALL have the port DONE, output, 1 bit: one-cycle completion pulse.
REQ-013 The block SHALL have the port STEP_3_0, output, 4 bits: remaining iteration count.

Function
REQ-014 The block SHALL implement the states IDLE, LOAD, ITER, FIX and FIN.
REQ-015 In IDLE the block SHALL drive QSEL=00, ALUOP=000, QLI=0 and BUSY=0.
REQ-016 When START=1 in IDLE, the block SHALL capture OPDIV and go to LOAD on the next edge.
REQ-017 In IDLE, START=0 SHALL hold the block in IDLE.
REQ-018 LOAD SHALL be one cycle with QSEL=01 and ALUOP=000, so that Q loads the operand from F.
REQ-019 LOAD SHALL set STEP to 15, clear the sign flag NEG, and transition to ITER.
REQ-020 In ITER for multiply, the block SHALL drive ALUOP=010 when Q15=1 and ALUOP=001 when Q15=0, with QSEL=10 and QLI=0.
REQ-021 In ITER for divide, the block SHALL drive ALUOP=011 when NEG=0 and ALUOP=010 when NEG=1.
REQ-022 In ITER for divide, the block SHALL drive QSEL=10 and QLI=~F15 (combinational), and register NEG<=F15 at the edge.
REQ-023 Each ITER cycle SHALL decrement STEP.
REQ-024 Each operation SHALL run exactly 16 ITER cycles; the ITER cycle with STEP=0 is the last.
REQ-025 After the last ITER cycle, the block SHALL go to FIX for divide and to FIN for multiply.
REQ-026 FIX SHALL be one cycle with ALUOP=100 when NEG=1 and ALUOP=000 when NEG=0, and QSEL=00.
REQ-027 FIX SHALL transition to FIN.
REQ-028 FIN SHALL be one cycle with DONE=1, BUSY=0, QSEL=00 and ALUOP=000, then go to IDLE.
REQ-029 START asserted during FIN SHALL be ignored.
REQ-030 Total latency from START sampled to DONE SHALL be 18 cycles for multiply and 19 cycles for divide.
REQ-031 STEP SHALL wrap from 0 only on the transition out of ITER and SHALL never underflow into another ITER.
REQ-032 START asserted while BUSY=1 SHALL be ignored, with no queuing.
REQ-033 ABORT=1 in LOAD, ITER or FIX SHALL force IDLE on the next edge with no DONE pulse.
REQ-034 ABORT=1 during any cycle SHALL force that cycle's QSEL=00 and ALUOP=000, so Q and A are not corrupted.
REQ-035 ABORT in IDLE or FIN SHALL have no effect.
REQ-036 ABORT and START asserted simultaneously in IDLE SHALL give priority to ABORT, keeping the block in IDLE.
REQ-037 QSEL, ALUOP and QLI SHALL be decoded from the state registers and inputs only.
REQ-038 QSEL, ALUOP and QLI SHALL settle within the cycle in which they are used.

Reset
REQ-039 RST_n=0 SHALL asynchronously force IDLE, STEP=0, NEG=0, the captured OPDIV=0, DONE=0 and BUSY=0.
REQ-040 While RST_n=0, the outputs SHALL be QSEL=00, ALUOP=000 and QLI=0.
REQ-041 Reset asserted mid-operation SHALL abandon the operation with no DONE pulse.
REQ-042 After RST_n rises, the first state change SHALL occur at the next ALUCLK edge, and only if START=1.

Verification
REQ-043 The bench SHALL check: multiply, with START=1 and OPDIV=0 while the Q operand 0xA001 is loaded -> LOAD shows QSEL=01, the next 16 cycles show QSEL=10 with ALUOP following Q15 (first cycle 010), and DONE pulses at cycle 18.
REQ-044 The bench SHALL check: divide, with F15 pattern 0,1,1,0,... -> QLI equals ~F15 each ITER, ALUOP alternates 011/010 per the registered NEG, FIX shows ALUOP=100 when the last F15=1, and DONE pulses at cycle 19.
REQ-045 The bench SHALL check: ABORT=1 at ITER with STEP=7 -> in that cycle QSEL=00 and ALUOP=000, then IDLE, with no DONE.
REQ-046 The bench SHALL check: START held high continuously -> operations run back-to-back with one IDLE cycle between FIN and the next LOAD, and START is ignored while BUSY=1.
REQ-047 The bench SHALL check: RST_n pulsed low during ITER with STEP=3 -> outputs are zero immediately, without a clock edge, and there is no DONE.
REQ-048 The bench SHALL check: START=1 with ABORT=1 in IDLE -> the block remains in IDLE with BUSY=0.
